// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU.
// Holds the operator codes, data-type codes and FSM state encoding used by
// seq_alu_param and its test environment.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam logic [3:0] DT_SIGNED   = 4'h1;
  localparam logic [3:0] DT_UNSIGNED = 4'h2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t FIN  = 2'd2;

endpackage

// File: rtl/seq_muldiv_core.sv
// Shared iterative multiply/divide datapath working on unsigned magnitudes.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_i              capture magnitudes and mode, clear the iteration counter
//   step_i              perform one iteration (one product or quotient bit)
//   div_i               mode captured on load: 1 divide, 0 multiply
//   mag_a_i, mag_b_i    multiplier/dividend and multiplicand/divisor magnitudes
//   prod_o              2*WIDTH-bit product magnitude
//   quot_o, rem_o       quotient and remainder magnitudes
//   last_iter_o         the next step is the final iteration
module seq_muldiv_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   mag_a_i,
  input  logic [WIDTH-1:0]   mag_b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               last_iter_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // hi/lo form one 2*WIDTH shift register: {acc, multiplier} for mul,
  // {partial remainder, dividend/quotient} for div.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic             div_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   add_sum, trial, diff;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    trial   = {hi_q, lo_q[WIDTH-1]};
    diff    = trial - {1'b0, b_q};
    if (load_i) begin
      hi_d  = '0;
      lo_d  = mag_a_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Restoring step: keep the difference only when it did not underflow.
        if (trial >= {1'b0, b_q}) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[WIDTH:1];
        lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        b_q   <= mag_b_i;
        div_q <= div_i;
      end
    end
  end

  assign prod_o      = {hi_q, lo_q};
  assign quot_o      = lo_q;
  assign rem_o       = hi_q;
  assign last_iter_o = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/seq_alu_param.sv
// Handshaked add/sub/mul/div ALU with signed and unsigned modes.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            request, accepted only while idle
//   dtype_i            4'h1 signed, 4'h2 unsigned
//   operator_i         5'h01 add, 5'h02 sub, 5'h03 mul, 5'h04 div
//   src1_i, src2_i     operands (dividend, divisor for div)
//   busy_o             an iterative operation is in flight
//   done_o             one-cycle pulse, results valid from this cycle
//   calc_res_o         2*WIDTH result, extended per dtype
//   rem_o              div remainder, 0 otherwise
//   ovf_o, err_o       overflow, divide-by-zero / illegal code
module seq_alu_param
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         dtype_i,
  input  logic [4:0]         operator_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] calc_res_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               ovf_o,
  output logic               err_o
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d, sgn_q, sgn_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               min_ovf_q, min_ovf_d, drain_q, drain_d;
  logic [2*WIDTH-1:0] calc_q, calc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d, err_q, err_d;

  logic               is_signed, dt_ok, op_ok, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     as_sum;
  logic [WIDTH-1:0]   as_res;
  logic               as_ovf;
  logic               core_load, core_step, last_iter;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quot_mag, rem_mag, quot_fix, rem_fix;

  // Operand decode from the live inputs; only consumed on the accept edge.
  always_comb begin
    is_signed = (dtype_i == DT_SIGNED);
    dt_ok     = (dtype_i == DT_SIGNED) || (dtype_i == DT_UNSIGNED);
    op_ok     = (operator_i >= OP_ADD) && (operator_i <= OP_DIV);
    a_neg     = is_signed & src1_i[WIDTH-1];
    b_neg     = is_signed & src2_i[WIDTH-1];
    mag_a     = a_neg ? -src1_i : src1_i;
    mag_b     = b_neg ? -src2_i : src2_i;
    if (operator_i == OP_SUB) begin
      as_sum = {1'b0, src1_i} - {1'b0, src2_i};
    end else begin
      as_sum = {1'b0, src1_i} + {1'b0, src2_i};
    end
    as_res = as_sum[WIDTH-1:0];
    if (is_signed) begin
      if (operator_i == OP_SUB) begin
        as_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (as_res[WIDTH-1] != src1_i[WIDTH-1]);
      end else begin
        as_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (as_res[WIDTH-1] != src1_i[WIDTH-1]);
      end
    end else begin
      as_ovf = as_sum[WIDTH];  // carry-out for add, borrow for sub
    end
  end

  // Sign restoration of the core's magnitude results.
  always_comb begin
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    quot_fix = neg_res_q ? -quot_mag : quot_mag;
    rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    min_ovf_d = min_ovf_q;
    drain_d   = drain_q;
    calc_d    = calc_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          core_load = 1'b1;
          is_div_d  = (operator_i == OP_DIV);
          sgn_d     = is_signed;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          min_ovf_d = is_signed && (src1_i == MinVal) && (src2_i == '1);
          drain_d   = 1'b0;
          if (!dt_ok || !op_ok) begin
            state_d = FIN;
            calc_d  = '0;
            rem_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end else if ((operator_i == OP_DIV) && (src2_i == '0)) begin
            state_d = FIN;
            calc_d  = '1;
            rem_d   = src1_i;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end else if ((operator_i == OP_ADD) || (operator_i == OP_SUB)) begin
            state_d = FIN;
            calc_d  = is_signed ? {{WIDTH{as_res[WIDTH-1]}}, as_res} : {{WIDTH{1'b0}}, as_res};
            rem_d   = '0;
            ovf_d   = as_ovf;
            err_d   = 1'b0;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        // One drain cycle after the last iteration lets the core settle before capture.
        if (drain_q) begin
          state_d = FIN;
          drain_d = 1'b0;
          err_d   = 1'b0;
          if (is_div_q) begin
            calc_d = sgn_q ? {{WIDTH{quot_fix[WIDTH-1]}}, quot_fix} : {{WIDTH{1'b0}}, quot_fix};
            rem_d  = rem_fix;
            ovf_d  = min_ovf_q;
          end else begin
            calc_d = prod_fix;
            rem_d  = '0;
            ovf_d  = 1'b0;
          end
        end else begin
          core_step = 1'b1;
          if (last_iter) begin
            drain_d = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      min_ovf_q <= 1'b0;
      drain_q   <= 1'b0;
      calc_q    <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      min_ovf_q <= min_ovf_d;
      drain_q   <= drain_d;
      calc_q    <= calc_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  seq_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (core_load),
    .step_i      (core_step),
    .div_i       (operator_i == OP_DIV),
    .mag_a_i     (mag_a),
    .mag_b_i     (mag_b),
    .prod_o      (prod_mag),
    .quot_o      (quot_mag),
    .rem_o       (rem_mag),
    .last_iter_o (last_iter)
  );

  assign busy_o     = (state_q == EXEC);
  assign done_o     = (state_q == FIN);
  assign calc_res_o = calc_q;
  assign rem_o      = rem_q;
  assign ovf_o      = ovf_q;
  assign err_o      = err_q;

endmodule
